// File: rtl/mux_2to1_pkg.sv
// Shared select encodings for the 2:1 steering mux.
// Used by the select process and the benches.
package mux_pkg;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef logic sel_t;

endpackage

// File: rtl/mux_2to1_if.sv
// Data/select bundle for the 2:1 mux.
// The master drives A/B/SEL/EN and the slave returns OUT/OUT_BAR.
interface mux_2to1_if #(
  parameter int WIDTH = 1
);

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             SEL;
  logic             EN;
  logic [WIDTH-1:0] OUT;
  logic [WIDTH-1:0] OUT_BAR;

  modport master (
    output A,
    output B,
    output SEL,
    output EN,
    input  OUT,
    input  OUT_BAR
  );

  modport slave (
    input  A,
    input  B,
    input  SEL,
    input  EN,
    output OUT,
    output OUT_BAR
  );

endinterface

// File: rtl/mux_2to1_out_reg.sv
// Enabled output register with an asynchronous active-low clear.
// It holds its value when en_i is low.
module mux_out_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] out_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q <= '0;
    end else if (en_i) begin
      out_q <= d_i;
    end
  end

  assign q_o = out_q;

endmodule

// File: rtl/mux_2to1.sv
// 2:1 selector with complementary outputs.
// The output path is either combinational or registered.
module mux_2to1
  import mux_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b0
) (
  input logic       CLK,
  input logic       RST_N,
  mux_2to1_if.slave bus
);

  logic [WIDTH-1:0] mux_d;
  logic [WIDTH-1:0] out_s;

  // An unknown select yields X rather than silently picking A.
  always_comb begin
    mux_d = '0;
    if (bus.SEL == SEL_B) begin
      mux_d = bus.B;
    end else if (bus.SEL == SEL_A) begin
      mux_d = bus.A;
    end else begin
      mux_d = 'x;
    end
  end

  if (REG_OUT) begin : g_reg
    mux_out_reg #(
      .WIDTH (WIDTH)
    ) u_out_reg (
      .clk_i  (CLK),
      .rst_ni (RST_N),
      .en_i   (bus.EN),
      .d_i    (mux_d),
      .q_o    (out_s)
    );
  end else begin : g_comb
    logic unused_ok;
    assign unused_ok = &{1'b0, CLK, RST_N, bus.EN};
    assign out_s = mux_d;
  end

  // OUT_BAR is the inverse of the same value, never a second flop.
  assign bus.OUT     = out_s;
  assign bus.OUT_BAR = ~out_s;

endmodule

// File: tb/tb_mux_2to1.sv
// Directed bench for mux_2to1.
// Covers the combinational 1-bit build and the registered 8-bit build.
module tb_mux_2to1;
  import mux_pkg::*;

  logic clk;
  logic rst_n;
  logic clk_run;
  int   checks;
  int   errors;

  mux_2to1_if #(.WIDTH(1)) c_if ();
  mux_2to1_if #(.WIDTH(8)) r_if ();

  mux_2to1 #(
    .WIDTH   (1),
    .REG_OUT (1'b0)
  ) u_comb (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (c_if)
  );

  mux_2to1 #(
    .WIDTH   (8),
    .REG_OUT (1'b1)
  ) u_reg (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (r_if)
  );

  initial begin
    clk = 1'b0;
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  task automatic check(
    input string    tag,
    input logic [7:0] obs,
    input logic [7:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Complement check on every falling edge for both builds.
  always @(negedge clk) begin
    if (!$isunknown(r_if.OUT)) begin
      check("reg_compl", r_if.OUT ^ r_if.OUT_BAR, 8'hFF);
    end
    if (!$isunknown(c_if.OUT)) begin
      check("comb_compl", {7'd0, c_if.OUT ^ c_if.OUT_BAR}, 8'h01);
    end
  end

  initial begin
    logic s;
    logic a;
    logic b;
    logic e;
    checks  = 0;
    errors  = 0;
    clk_run = 1'b0;
    rst_n   = 1'b1;
    c_if.A = 1'b0; c_if.B = 1'b0;
    c_if.SEL = SEL_A; c_if.EN = 1'b1;
    r_if.A = 8'h00; r_if.B = 8'h00;
    r_if.SEL = SEL_A; r_if.EN = 1'b0;

    #1 rst_n = 1'b0;
    #1;
    check("rst_out", r_if.OUT, 8'h00);
    check("rst_bar", r_if.OUT_BAR, 8'hFF);

    c_if.SEL = 1'b0; c_if.A = 1'b1; c_if.B = 1'b0;
    #10;
    check("v0_out", {7'd0, c_if.OUT}, 8'h01);
    check("v0_bar", {7'd0, c_if.OUT_BAR}, 8'h00);
    c_if.SEL = 1'b1; c_if.A = 1'b0; c_if.B = 1'b1;
    #10;
    check("v1_out", {7'd0, c_if.OUT}, 8'h01);
    check("v1_bar", {7'd0, c_if.OUT_BAR}, 8'h00);
    c_if.SEL = 1'b0; c_if.A = 1'b0; c_if.B = 1'b1;
    #10;
    check("v2_out", {7'd0, c_if.OUT}, 8'h00);
    check("v2_bar", {7'd0, c_if.OUT_BAR}, 8'h01);
    c_if.SEL = 1'b1; c_if.A = 1'b1; c_if.B = 1'b0;
    #10;
    check("v3_out", {7'd0, c_if.OUT}, 8'h00);
    check("v3_bar", {7'd0, c_if.OUT_BAR}, 8'h01);

    for (int i = 0; i < 8; i++) begin
      s = i[2]; a = i[1]; b = i[0];
      c_if.SEL = s; c_if.A = a; c_if.B = b;
      #10;
      e = s ? b : a;
      check("sweep_out", {7'd0, c_if.OUT}, {7'd0, e});
      check("sweep_bar", {7'd0, c_if.OUT_BAR}, {7'd0, ~e});
    end

    check("rst_hold_noclk", r_if.OUT, 8'h00);

    clk_run = 1'b1;
    r_if.A = 8'h5A; r_if.B = 8'hC3;
    r_if.SEL = SEL_B; r_if.EN = 1'b1;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("load_b", r_if.OUT, 8'hC3);
    check("load_b_bar", r_if.OUT_BAR, 8'h3C);

    r_if.EN = 1'b0; r_if.SEL = SEL_A;
    @(posedge clk); #1;
    check("hold1", r_if.OUT, 8'hC3);
    @(posedge clk); #1;
    check("hold2", r_if.OUT, 8'hC3);

    r_if.EN = 1'b1;
    @(posedge clk); #1;
    check("load_a", r_if.OUT, 8'h5A);

    #2 rst_n = 1'b0;
    #1;
    check("async_clr", r_if.OUT, 8'h00);
    check("async_clr_bar", r_if.OUT_BAR, 8'hFF);
    @(posedge clk); #1;
    check("clr_hold_rst", r_if.OUT, 8'h00);

    r_if.EN = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("clr_hold_en0", r_if.OUT, 8'h00);
    r_if.EN = 1'b1;
    @(posedge clk); #1;
    check("first_load", r_if.OUT, 8'h5A);

    r_if.A = 8'h33; r_if.B = 8'h33;
    r_if.SEL = SEL_A;
    @(posedge clk); #1;
    check("eq_sel0", r_if.OUT, 8'h33);
    r_if.SEL = SEL_B;
    @(posedge clk); #1;
    check("eq_sel1", r_if.OUT, 8'h33);

    r_if.A = 8'h11; r_if.B = 8'h22;
    r_if.SEL = SEL_A;
    @(posedge clk); #1;
    check("tog_a0", r_if.OUT, 8'h11);
    r_if.SEL = SEL_B;
    #1;
    check("tog_lag", r_if.OUT, 8'h11);
    @(posedge clk); #1;
    check("tog_b", r_if.OUT, 8'h22);
    r_if.SEL = SEL_A;
    @(posedge clk); #1;
    check("tog_a1", r_if.OUT, 8'h11);

    clk_run = 1'b0;
    #20;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
